// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares the single SDRAM access port between the input-image fetch path
//   (reads) and the output-image writeback path (writes). One transaction is
//   in flight at a time. When both sides request together, the side that was
//   not served last wins. A wait watchdog forces completion so that every
//   request is eventually granted.
//
// Ports
//   clk, n_rst            clock (rising edge), asynchronous active-low reset
//   rd_req/rd_addr        read request (level) and address
//   rd_grant/rd_data      one-cycle completion pulse, registered read data
//   wr_req/wr_addr/wr_data write request (level), address and data
//   wr_grant              one-cycle write completion pulse
//   mem_read_en/_write_en one-cycle strobes to the SDRAM controller
//   mem_addr/mem_wdata    registered transaction address / write data
//   mem_rdata/mem_done    controller read data and completion pulse
//   err_clr/timeout_err   clear input and sticky watchdog flag
//   busy                  high whenever a transaction is being handled
module sdram_arbiter #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_grant,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  input  logic              err_clr,
  output logic              timeout_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_RESP
  } state_t;

  // The counter starts at 0 in the first WAIT cycle, so the last permitted
  // WAIT cycle is the one where it holds TIMEOUT-1 (TIMEOUT WAIT cycles total).
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       last_wr;     // 1: the most recently granted transaction was a write
  logic       dir_wr;      // direction of the transaction in flight
  logic       start;
  logic       pick_wr;
  logic       in_wait;
  logic       expired;
  logic       timeout_hit;

  // Fair choice: a lone requester always wins; under contention the side
  // that did not go last gets the port.
  assign pick_wr     = wr_req && (!rd_req || !last_wr);
  assign start       = (state == S_IDLE) && (rd_req || wr_req);
  assign in_wait     = (state == S_RD_WAIT) || (state == S_WR_WAIT);
  assign expired     = (wait_cnt == LAST_WAIT);
  // A completion arriving in the final WAIT cycle still counts as success.
  assign timeout_hit = in_wait && !mem_done && expired;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (rd_req || wr_req) begin
          state_nxt = pick_wr ? S_WR_ISSUE : S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: state_nxt = S_RD_WAIT;
      S_WR_ISSUE: state_nxt = S_WR_WAIT;
      S_RD_WAIT, S_WR_WAIT: begin
        if (mem_done || expired) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from state so strobes and grants are exactly one
  // cycle wide and can never overlap.
  always_comb begin
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    rd_grant     = 1'b0;
    wr_grant     = 1'b0;
    busy         = (state != S_IDLE);
    case (state)
      S_RD_ISSUE: mem_read_en  = 1'b1;
      S_WR_ISSUE: mem_write_en = 1'b1;
      S_RESP: begin
        rd_grant = !dir_wr;
        wr_grant = dir_wr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wait_cnt    <= '0;
      last_wr     <= 1'b1;
      dir_wr      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == S_RD_ISSUE) || (state == S_WR_ISSUE)) begin
        wait_cnt <= '0;
      end else if (in_wait) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (start) begin
        dir_wr <= pick_wr;
      end
      if (state == S_RESP) begin
        last_wr <= dir_wr;
      end
      // A new timeout wins over a simultaneous clear.
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

  // Transaction registers hold between transactions; rd_data changes only
  // when a read finishes (real data or forced zero on timeout).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_data   <= '0;
    end else begin
      if (start) begin
        mem_addr <= pick_wr ? wr_addr : rd_addr;
        if (pick_wr) begin
          mem_wdata <= wr_data;
        end
      end
      if (state == S_RD_WAIT) begin
        if (mem_done) begin
          rd_data <= mem_rdata;
        end else if (expired) begin
          rd_data <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_grant;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_grant;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              err_clr;
  logic              timeout_err;
  logic              busy;

  int n_vec = 0;
  int n_mis = 0;

  sdram_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(4)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_grant    (rd_grant),
    .rd_data     (rd_data),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_grant    (wr_grant),
    .mem_read_en (mem_read_en),
    .mem_write_en(mem_write_en),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_done    (mem_done),
    .err_clr     (err_clr),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_grant"},  32'(rd_grant),     32'd0);
    chk({tag, "_wr_grant"},  32'(wr_grant),     32'd0);
    chk({tag, "_rd_data"},   32'(rd_data),      32'd0);
    chk({tag, "_rd_en"},     32'(mem_read_en),  32'd0);
    chk({tag, "_wr_en"},     32'(mem_write_en), 32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),     32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata),    32'd0);
    chk({tag, "_terr"},      32'(timeout_err),  32'd0);
    chk({tag, "_busy"},      32'(busy),         32'd0);
  endtask

  initial begin
    logic [1:0] gseq [4];
    int         ng;
    int         overlap;
    int         stray_grants;
    logic       pending;

    n_rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0; rd_addr = '0; wr_addr = '0;
    wr_data = '0; mem_rdata = '0; mem_done = 1'b0; err_clr = 1'b0;

    // Reset state
    repeat (3) tick();
    chk_all_zero("rst_held");
    n_rst = 1'b1;
    tick();
    chk_all_zero("rst_rel");

    // Single read: done 2 cycles after the strobe, grant at cycle 4
    rd_addr = 22'h000123; mem_rdata = 16'hBEEF; rd_req = 1'b1;
    tick();
    chk("rd_strobe",      32'(mem_read_en),  32'd1);
    chk("rd_no_wstrobe",  32'(mem_write_en), 32'd0);
    chk("rd_addr",        32'(mem_addr),     32'h000123);
    chk("rd_busy_issue",  32'(busy),         32'd1);
    tick();
    chk("rd_strobe_1cyc", 32'(mem_read_en),  32'd0);
    tick();
    chk("rd_no_early_gnt", 32'(rd_grant),    32'd0);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("rd_grant",       32'(rd_grant),     32'd1);
    chk("rd_data",        32'(rd_data),      32'h0000BEEF);
    chk("rd_busy_resp",   32'(busy),         32'd1);
    rd_req = 1'b0;
    tick();
    chk("rd_grant_1cyc",  32'(rd_grant),     32'd0);
    chk("rd_idle_busy",   32'(busy),         32'd0);
    chk("rd_data_hold",   32'(rd_data),      32'h0000BEEF);

    // Single write: immediate done, grant 3 cycles after the request
    wr_addr = 22'h3FFFFF; wr_data = 16'hA5A5; wr_req = 1'b1;
    tick();
    chk("wr_strobe",      32'(mem_write_en), 32'd1);
    chk("wr_no_rstrobe",  32'(mem_read_en),  32'd0);
    chk("wr_addr",        32'(mem_addr),     32'h3FFFFF);
    chk("wr_wdata",       32'(mem_wdata),    32'h0000A5A5);
    tick();
    chk("wr_strobe_1cyc", 32'(mem_write_en), 32'd0);
    chk("wr_no_early_gnt", 32'(wr_grant),    32'd0);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("wr_grant",       32'(wr_grant),     32'd1);
    chk("wr_no_rd_grant", 32'(rd_grant),     32'd0);
    wr_req = 1'b0;
    tick();
    chk("wr_grant_1cyc",  32'(wr_grant),     32'd0);
    chk("wr_rd_data_keep", 32'(rd_data),     32'h0000BEEF);

    // Stray mem_done in IDLE
    mem_rdata = 16'h1111; mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("stray_idle_rgnt", 32'(rd_grant),    32'd0);
    chk("stray_idle_wgnt", 32'(wr_grant),    32'd0);
    chk("stray_idle_busy", 32'(busy),        32'd0);
    chk("stray_idle_data", 32'(rd_data),     32'h0000BEEF);

    // Stray mem_done during RD_ISSUE, real completion later
    rd_addr = 22'h000055; rd_req = 1'b1;
    tick();
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("stray_iss_busy",  32'(busy),        32'd1);
    chk("stray_iss_data",  32'(rd_data),     32'h0000BEEF);
    tick();
    chk("stray_iss_nognt", 32'(rd_grant),    32'd0);
    mem_rdata = 16'h2222; mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("stray_iss_grant", 32'(rd_grant),    32'd1);
    chk("stray_iss_rdata", 32'(rd_data),     32'h00002222);
    rd_req = 1'b0;
    tick();

    // Timeout (TIMEOUT=4): grant at cycle 6, rd_data forced to 0
    rd_addr = 22'h000077; rd_req = 1'b1;
    repeat (5) tick();
    chk("to_no_grant_c5",  32'(rd_grant),    32'd0);
    chk("to_no_err_c5",    32'(timeout_err), 32'd0);
    tick();
    chk("to_grant_c6",     32'(rd_grant),    32'd1);
    chk("to_rd_data_zero", 32'(rd_data),     32'd0);
    chk("to_err_set",      32'(timeout_err), 32'd1);
    rd_req = 1'b0;
    repeat (2) tick();
    chk("to_err_sticky",   32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_err_cleared",  32'(timeout_err), 32'd0);

    // err_clr in the same cycle as a new timeout: set wins
    rd_req = 1'b1;
    repeat (5) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_set_dominates", 32'(timeout_err), 32'd1);
    chk("to_grant_2",       32'(rd_grant),    32'd1);
    rd_req = 1'b0;
    tick();

    // Reset asserted mid RD_WAIT: transaction abandoned, no grant afterwards
    rd_addr = 22'h000099; rd_req = 1'b1;
    repeat (3) tick();
    chk("mid_rst_in_wait", 32'(busy), 32'd1);
    n_rst = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    rd_req = 1'b0;
    tick();
    n_rst = 1'b1;
    stray_grants = 0;
    for (int c = 0; c < 6; c++) begin
      mem_done = (c == 1);
      tick();
      if (rd_grant || wr_grant || busy) stray_grants++;
    end
    mem_done = 1'b0;
    chk("mid_rst_no_grant", 32'(stray_grants), 32'd0);

    // Contention: both held, immediate done -> R, W, R, W
    rd_addr = 22'h000010; wr_addr = 22'h000020; wr_data = 16'hC3C3;
    mem_rdata = 16'h4444;
    for (int i = 0; i < 4; i++) gseq[i] = 2'd3;
    ng = 0; overlap = 0; pending = 1'b0;
    rd_req = 1'b1; wr_req = 1'b1;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      tick();
      mem_done = pending;
      pending  = mem_read_en | mem_write_en;
      if (mem_read_en && mem_write_en) overlap++;
      if (mem_read_en)  chk("cont_rd_addr", 32'(mem_addr), 32'h000010);
      if (mem_write_en) chk("cont_wr_addr", 32'(mem_addr), 32'h000020);
      if (mem_write_en) chk("cont_wdata",   32'(mem_wdata), 32'h0000C3C3);
      if (rd_grant && ng < 4) begin gseq[ng] = 2'd0; ng++; end
      else if (wr_grant && ng < 4) begin gseq[ng] = 2'd1; ng++; end
    end
    rd_req = 1'b0; wr_req = 1'b0; mem_done = 1'b0;
    chk("cont_ngrants", 32'(ng), 32'd4);
    chk("cont_g0_R", 32'(gseq[0]), 32'd0);
    chk("cont_g1_W", 32'(gseq[1]), 32'd1);
    chk("cont_g2_R", 32'(gseq[2]), 32'd0);
    chk("cont_g3_W", 32'(gseq[3]), 32'd1);
    chk("cont_no_overlap", 32'(overlap), 32'd0);
    chk("cont_rd_data", 32'(rd_data), 32'h00004444);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
